aes_inv_cipher_iter: RTL and testbench

Iterative AES-128 inverse cipher, the decrypt-side counterpart of the encrypt round datapath. It accepts a 4x4 ciphertext state over a valid/ready handshake and applies the initial AddRoundKey, nine full inverse rounds and the final inverse round, one stage per clock. Round keys come from an external key-schedule store, addressed by an index the block drives. The block returns the 4x4 plaintext state on a valid/ready output handshake.

---
 rtl/aes_pkg.sv | 27 ++
 rtl/aes_inv_mixcolumn.sv | 19 +
 rtl/aes_inv_cipher_iter.sv | 77 +++++++
 tb/tb_aes_inv_cipher_iter.sv | 276 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/aes_pkg.sv
// aes_pkg: shared AES types, round constants, inverse S-box and GF(2^8) doubling.
package aes_pkg;
  typedef logic [3:0][3:0][7:0] state_t;
  localparam int NR      = 10;
  localparam int RK_LAST = 10;
  localparam logic [0:255][7:0] INV_SBOX = {
    128'h52096ad53036a538bf40a39e81f3d7fb,
    128'h7ce339829b2fff87348e4344c4dee9cb,
    128'h547b9432a6c2233dee4c950b42fac34e,
    128'h082ea16628d924b2765ba2496d8bd125,
    128'h72f8f66486689816d4a45ccc5d65b692,
    128'h6c704850fdedb9da5e154657a78d9d84,
    128'h90d8ab008cbcd30af7e45805b8b34506,
    128'hd02c1e8fca3f0f02c1afbd0301138a6b,
    128'h3a9111414f67dcea97f2cfcef0b4e673,
    128'h96ac7422e7ad3585e2f937e81c75df6e,
    128'h47f11a711d29c5896fb7620eaa18be1b,
    128'hfc563e4bc6d279209adbc0fe78cd5af4,
    128'h1fdda8338807c731b11210592780ec5f,
    128'h60517fa919b54a0d2de57a9f93c99cef,
    128'ha0e03b4dae2af5b0c8ebbb3c83539961,
    128'h172b047eba77d626e169146355210c7d
  };
  function automatic logic [7:0] gf_mul2(input logic [7:0] a);
    return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
  endfunction
endpackage

// File: rtl/aes_inv_mixcolumn.sv
// aes_inv_mixcolumn: InvMixColumns on a single column, combinational.
module aes_inv_mixcolumn
  import aes_pkg::*;
(
  input  logic [3:0][7:0] i_col,
  output logic [3:0][7:0] o_col
);
  logic [3:0][7:0] w_x2, w_x4, w_x8;
  for (genvar r = 0; r < 4; r++) begin : g_row
    assign w_x2[r] = gf_mul2(i_col[r]);
    assign w_x4[r] = gf_mul2(w_x2[r]);
    assign w_x8[r] = gf_mul2(w_x4[r]);
    // 0e*a[r] ^ 0b*a[r+1] ^ 0d*a[r+2] ^ 09*a[r+3]
    assign o_col[r] = (w_x8[r] ^ w_x4[r] ^ w_x2[r])
                    ^ (w_x8[(r+1)%4] ^ w_x2[(r+1)%4] ^ i_col[(r+1)%4])
                    ^ (w_x8[(r+2)%4] ^ w_x4[(r+2)%4] ^ i_col[(r+2)%4])
                    ^ (w_x8[(r+3)%4] ^ i_col[(r+3)%4]);
  end
endmodule

// File: rtl/aes_inv_cipher_iter.sv
// aes_inv_cipher_iter: iterative AES-128 inverse cipher, one round per clock.
// Define AES_INV_BACKTOBACK_EN to accept the next block while DONE hands off.
module aes_inv_cipher_iter
  import aes_pkg::*;
#(
  parameter int RKW = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [3:0][3:0][7:0]  data_in,
  output logic [RKW-1:0]        rk_idx,
  input  logic [3:0][3:0][7:0]  rk,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [3:0][3:0][7:0]  data_out,
  output logic                  busy
);
  typedef enum logic [1:0] {S_IDLE, S_ROUND, S_DONE} fsm_t;
  fsm_t              r_fsm, w_fsm_nxt;
  logic [RKW-1:0]    r_cnt;
  state_t            r_state, w_t, w_mc;
  logic [3:0][3:0][7:0] w_col;
  logic              w_load;

  assign w_load = in_valid & in_ready;

  always_ff @(posedge clk or negedge rst)
    if (!rst) r_fsm <= S_IDLE;
    else      r_fsm <= w_fsm_nxt;

  always_comb
    w_fsm_nxt = (r_fsm == S_IDLE)  ? (w_load ? S_ROUND : S_IDLE) :
                (r_fsm == S_ROUND) ? ((r_cnt == '0) ? S_DONE : S_ROUND) :
                (r_fsm == S_DONE)  ? (out_ready ? (w_load ? S_ROUND : S_IDLE) : S_DONE) :
                S_IDLE;

  always_comb begin
`ifdef AES_INV_BACKTOBACK_EN
    in_ready  = (r_fsm == S_IDLE) || (r_fsm == S_DONE && out_ready);
`else
    in_ready  = (r_fsm == S_IDLE);
`endif
    rk_idx    = (r_fsm == S_ROUND) ? r_cnt : RKW'(RK_LAST);
    out_valid = (r_fsm == S_DONE);
    busy      = (r_fsm != S_IDLE);
    data_out  = r_state;
  end

  // InvShiftRows folded into the S-box read: row r rotated right by r
  for (genvar r = 0; r < 4; r++) begin : g_r
    for (genvar c = 0; c < 4; c++) begin : g_c
      assign w_t[r][c] = INV_SBOX[r_state[r][(c + 4 - r) % 4]] ^ rk[r][c];
      assign w_mc[r][c] = w_col[c][r];
    end
  end

  for (genvar c = 0; c < 4; c++) begin : g_mc
    aes_inv_mixcolumn u_mc (
      .i_col({w_t[3][c], w_t[2][c], w_t[1][c], w_t[0][c]}),
      .o_col(w_col[c])
    );
  end

  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      r_cnt   <= '0;
      r_state <= '0;
    end else if (w_load) begin
      r_state <= data_in ^ rk;
      r_cnt   <= RKW'(NR - 1);
    end else if (r_fsm == S_ROUND) begin
      r_state <= (r_cnt == '0) ? w_t : w_mc;
      r_cnt   <= (r_cnt == '0) ? r_cnt : r_cnt - RKW'(1);
    end
endmodule

// File: tb/tb_aes_inv_cipher_iter.sv
// tb_aes_inv_cipher_iter: vector table plus handshake corner cases against a
// byte-level AES-128 decryption model built from GF(2^8) arithmetic.
module tb_aes_inv_cipher_iter;
  logic clk, rst, in_valid, in_ready, out_valid, out_ready, busy;
  logic [3:0][3:0][7:0] data_in, rk, data_out;
  logic [3:0] rk_idx;
  logic [7:0] sbox [256];
  logic [7:0] isbox [256];
  logic [127:0] rks [0:10];
  int errors = 0, checks = 0, bad_idx = 0;

  localparam logic [127:0] C1_KEY  = 128'h000102030405060708090a0b0c0d0e0f;
  localparam logic [127:0] C1_CT   = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
  localparam logic [127:0] C1_PT   = 128'h00112233445566778899aabbccddeeff;
  localparam logic [127:0] C1_RK10 = 128'h13111d7fe3944a17f307a78b4d2b30c5;

  typedef struct {
    logic [127:0] key;
    logic [127:0] ct;
    logic [127:0] pt;
  } vec_t;
  vec_t tv [6];

  aes_inv_cipher_iter dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .data_in(data_in), .rk_idx(rk_idx), .rk(rk), .out_valid(out_valid),
    .out_ready(out_ready), .data_out(data_out), .busy(busy)
  );

  initial clk = 0;
  always #5 clk = ~clk;

  function automatic logic [3:0][3:0][7:0] to_state(input logic [127:0] b);
    logic [3:0][3:0][7:0] s;
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++)
        s[r][c] = b[127 - 8*(4*c + r) -: 8];
    return s;
  endfunction

  always_comb rk = to_state(rks[(rk_idx > 4'd10) ? 4'd0 : rk_idx]);
  always @(negedge clk) if (rst && rk_idx > 4'd10) bad_idx++;

  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p = 0;
    for (int i = 0; i < 8; i++) begin
      if (b[0]) p = p ^ a;
      a = {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
      b = b >> 1;
    end
    return p;
  endfunction

  function automatic logic [7:0] rotl(input logic [7:0] v, input int k);
    logic [15:0] t = {v, v} << k;
    return t[15:8];
  endfunction

  function automatic logic [127:0] rnd128();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  task automatic build_sbox();
    logic [7:0] inv, s;
    for (int x = 0; x < 256; x++) begin
      inv = 0;
      for (int y = 1; y < 256; y++)
        if (x != 0 && gmul(8'(x), 8'(y)) == 8'h01) inv = 8'(y);
      s = inv ^ rotl(inv, 1) ^ rotl(inv, 2) ^ rotl(inv, 3) ^ rotl(inv, 4) ^ 8'h63;
      sbox[x] = s;
      isbox[s] = 8'(x);
    end
  endtask

  task automatic expand(input logic [127:0] key);
    logic [31:0] w [44];
    logic [31:0] t;
    logic [7:0] rc = 8'h01;
    for (int i = 0; i < 4; i++) w[i] = key[127 - 32*i -: 32];
    for (int i = 4; i < 44; i++) begin
      t = w[i-1];
      if (i % 4 == 0) begin
        t = {sbox[t[23:16]], sbox[t[15:8]], sbox[t[7:0]], sbox[t[31:24]]} ^ {rc, 24'h0};
        rc = gmul(rc, 8'h02);
      end
      w[i] = w[i-4] ^ t;
    end
    for (int r = 0; r <= 10; r++) rks[r] = {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
  endtask

  // Textbook InvCipher over the FIPS byte order (byte 4c+r), using the current rks
  function automatic logic [127:0] decrypt(input logic [127:0] ct);
    logic [127:0] s, t;
    logic [0:3][7:0] m;
    logic [7:0] acc;
    m = {8'h0e, 8'h0b, 8'h0d, 8'h09};
    s = ct ^ rks[10];
    for (int rnd = 9; rnd >= 0; rnd--) begin
      for (int r = 0; r < 4; r++)
        for (int c = 0; c < 4; c++)
          t[127 - 8*(4*((c + r) % 4) + r) -: 8] = isbox[s[127 - 8*(4*c + r) -: 8]];
      s = t ^ rks[rnd];
      if (rnd != 0) begin
        t = s;
        for (int c = 0; c < 4; c++)
          for (int r = 0; r < 4; r++) begin
            acc = 0;
            for (int k = 0; k < 4; k++)
              acc = acc ^ gmul(m[(k - r + 4) % 4], t[127 - 8*(4*c + k) -: 8]);
            s[127 - 8*(4*c + r) -: 8] = acc;
          end
      end
    end
    return s;
  endfunction

  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic chki(input string nm, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  task automatic run_block(input logic [127:0] ct, input logic [127:0] exp, input string nm);
    int n, bad;
    data_in = to_state(ct); in_valid = 1; out_ready = 1;
    #1;
    chki({nm, " in_ready"}, int'(in_ready), 1);
    chki({nm, " rk_idx idle"}, int'(rk_idx), 10);
    @(posedge clk); #1;
    in_valid = 0; data_in = to_state(rnd128());
    n = 1; bad = 0;
    while (!out_valid && n < 30) begin
      if (rk_idx != 4'(10 - n)) bad++;
      @(posedge clk); #1; n++;
    end
    chki({nm, " latency"}, n, 11);
    chki({nm, " rk_idx seq"}, bad, 0);
    chk({nm, " data_out"}, data_out, to_state(exp));
    @(posedge clk); #1;
    chki({nm, " out_valid drop"}, int'(out_valid), 0);
  endtask

  initial begin
    int n, bad, seen, e;
    int t [3];
    logic [127:0] exp;
    build_sbox();
    rst = 1; in_valid = 0; out_ready = 0; data_in = '0;
    expand(C1_KEY);
    #2 rst = 0;
    #10;
    chki("reset out_valid", int'(out_valid), 0);
    chki("reset busy", int'(busy), 0);
    chki("reset in_ready", int'(in_ready), 1);
    chki("reset rk_idx", int'(rk_idx), 10);
    chk("reset data_out", data_out, '0);
    @(negedge clk) rst = 1;
    @(posedge clk); #1;
    chki("post-reset in_ready", int'(in_ready), 1);

    chk("model rk10", rks[10], C1_RK10);
    chk("model C.1", decrypt(C1_CT), C1_PT);
    chki("model isbox 00", int'(isbox[0]), 'h52);

    tv[0] = '{C1_KEY, C1_CT, C1_PT};
    tv[1] = '{128'h0, 128'h0, 128'h0};
    for (int i = 2; i < 6; i++) tv[i] = '{rnd128(), rnd128(), 128'h0};
    for (int i = 1; i < 6; i++) begin
      expand(tv[i].key);
      tv[i].pt = decrypt(tv[i].ct);
    end
    for (int i = 0; i < 6; i++) begin
      expand(tv[i].key);
      run_block(tv[i].ct, tv[i].pt, $sformatf("vec%0d", i));
    end

    // Backpressure: output held for 5 cycles with in_valid pulsing at the door
    expand(C1_KEY);
    data_in = to_state(C1_CT); in_valid = 1; out_ready = 0;
    @(posedge clk); #1;
    in_valid = 0;
    n = 1;
    while (!out_valid && n < 30) begin @(posedge clk); #1; n++; end
    chki("bp latency", n, 11);
    in_valid = 1; data_in = to_state(rnd128());
    bad = 0;
    for (int i = 0; i < 5; i++) begin
      if (out_valid !== 1'b1 || data_out !== to_state(C1_PT) || in_ready !== 1'b0) bad++;
      @(posedge clk); #1;
    end
    chki("bp hold stable", bad, 0);
    in_valid = 0; out_ready = 1;
    @(posedge clk); #1;
    chki("bp handshake", int'(out_valid), 0);
    chki("bp idle", int'(busy), 0);
    @(posedge clk); #1;
    chki("bp single output", int'(out_valid), 0);

    // Garbage in_valid throughout ROUND must not disturb the block
    data_in = to_state(C1_CT); in_valid = 1; out_ready = 1;
    @(posedge clk); #1;
    n = 1; bad = 0;
    while (!out_valid && n < 30) begin
      data_in = to_state(rnd128());
      if (in_ready !== 1'b0) bad++;
      @(posedge clk); #1; n++;
    end
    in_valid = 0;
    chki("busy latency", n, 11);
    chki("busy in_ready low", bad, 0);
    chk("busy data_out", data_out, to_state(C1_PT));
    @(posedge clk); #1;
    chki("busy back idle", int'(busy), 0);

    // Reset while cnt=4
    data_in = to_state(C1_CT); in_valid = 1; out_ready = 1;
    @(posedge clk); #1;
    in_valid = 0;
    n = 0;
    while (rk_idx != 4'd4 && n < 30) begin @(posedge clk); #1; n++; end
    chki("rst reached cnt4", int'(rk_idx), 4);
    rst = 0;
    #1;
    chki("rst async busy", int'(busy), 0);
    chki("rst async out_valid", int'(out_valid), 0);
    #2 rst = 1;
    #1;
    chki("rst in_ready", int'(in_ready), 1);
    chki("rst rk_idx", int'(rk_idx), 10);
    @(posedge clk); #1;
    chki("rst stays idle", int'(busy), 0);
    run_block(C1_CT, C1_PT, "after-rst");

    // Back-to-back with in_valid held high
    data_in = to_state(C1_CT); in_valid = 1; out_ready = 1;
    seen = 0; e = 0; bad = 0; t = '{0, 0, 0};
    while (e < 60 && seen < 2) begin
      @(posedge clk); #1; e++;
      if (out_valid) begin
        seen++;
        t[seen] = e;
        if (data_out !== to_state(C1_PT)) bad++;
      end
    end
    in_valid = 0;
    chki("b2b outputs", seen, 2);
    chki("b2b data", bad, 0);
`ifdef AES_INV_BACKTOBACK_EN
    chki("b2b spacing", t[2] - t[1], 11);
`else
    chki("b2b spacing", t[2] - t[1], 12);
`endif
    @(posedge clk); #1;
    @(posedge clk); #1;
    chki("b2b idle", int'(busy), 0);

    // All-zero round keys and state
    for (int r = 0; r <= 10; r++) rks[r] = '0;
    exp = decrypt(128'h0);
    run_block(128'h0, exp, "zero");

    chki("rk_idx range", bad_idx, 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
